fifo_serial_tx: RTL and testbench
=================================

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  permits the start of new frames; sampled only in IDLE and at the last STOP cycle.
REQ-005 fifo_empty  input  1  FIFO empty flag from the 8-bit FIFO being drained.
REQ-006 fifo_data  input  8  FIFO head word, valid combinationally whenever fifo_empty=0.
REQ-007 fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is in progress (START through STOP).
REQ-010 frame_done  output  1  one-cycle pulse on the last cycle of each STOP bit.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (only with the macro), STOP.
REQ-012 In IDLE, when enable=1 and fifo_empty=0, fifo_rd SHALL be 1 for exactly that cycle, fifo_data SHALL be captured into the shift register on the same edge, and the next state SHALL be START.
REQ-013 fifo_rd SHALL never be 1 while fifo_empty=1, and SHALL pulse at most once per frame.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-015 DATA SHALL drive 8 bits, LSB first, each for CLKS_PER_BIT cycles, tracked by a 3-bit bit counter that wraps 7->0 on exit.
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, and frame_done SHALL be 1 on its final cycle.
REQ-017 On the final STOP cycle, if enable=1 and fifo_empty=0, the block SHALL pop (fifo_rd=1, capture) and go directly to START with no idle bit; otherwise it SHALL go to IDLE.
REQ-018 Deassertion of enable mid-frame SHALL NOT abort the frame; the current frame completes and no further pop occurs.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state transition.
REQ-020 tx SHALL be a registered output; busy SHALL be 1 in every state except IDLE.
REQ-021 The frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with the macro).

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, tx=1, busy=0, fifo_rd=0, frame_done=0, and zero all counters and the shift register.
REQ-023 Reset mid-frame SHALL abandon the byte without a further pop; after release, the next frame SHALL start from IDLE per REQ-012.

Configuration
REQ-024 With macro FIFO_SERIAL_TX_PARITY_EN defined, the PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP.
REQ-025 Without FIFO_SERIAL_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-026 FIFO holds 0xA5, enable=1 -> one fifo_rd pulse; tx=0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles); frame_done pulses at cycle 40 after the pop.
REQ-027 Parity build, FIFO holds 0xA5 then 0x07 -> parity bits 0 then 1; frames are 44 cycles each.
REQ-028 FIFO holds 0x55,0xAA back-to-back -> two fifo_rd pulses 40 cycles apart, no idle-high gap, busy high for 80 continuous cycles.
REQ-029 fifo_empty=1 held with enable=1 for 100 cycles -> fifo_rd never asserted, tx=1, busy=0.
REQ-030 enable dropped at cycle 10 of a frame with data still in FIFO -> the frame completes (40 cycles), no second fifo_rd, and the block returns to IDLE.
REQ-031 rst_n pulsed low at cycle 17 of a 0x3C frame -> immediately tx=1 and busy=0; after release with enable=1, the next pop occurs in the first IDLE cycle.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - FIFO-draining asynchronous serial transmitter (8N1, optional even parity)
//
// Pops bytes from an external 8-bit FIFO and sends each one as a serial frame:
// one START bit (0), eight DATA bits LSB first, an optional even-parity bit,
// and one STOP bit (1). Every bit lasts CLKS_PER_BIT clock cycles. When another
// byte is available at the end of STOP and enable is high, the next frame
// starts on the following cycle with no idle bit in between.
//
// Build option: define FIFO_SERIAL_TX_PARITY_EN to insert the even-parity bit
// (XOR of the eight data bits) between DATA and STOP.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, 2..65535
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   enable      permits new frames; looked at only in IDLE and the last STOP cycle
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word, valid whenever fifo_empty is low
//   fifo_rd     one-cycle pop strobe to the FIFO
//   tx          registered serial line, idle high
//   busy        high from START through STOP
//   frame_done  one-cycle pulse on the last cycle of each STOP bit

module fifo_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] baud_cnt;
    logic [15:0] next_baud;
    logic [2:0]  bit_cnt;
    logic [2:0]  next_bit;
    logic [7:0]  shreg;
    logic [7:0]  next_shreg;
    logic        next_tx;
    logic        baud_end;
    logic        pop;

`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic        parity;
    logic        next_parity;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    // A pop is only offered where a new frame may begin. rst_n is folded in so
    // the FIFO is never popped while this block is held in reset and cannot
    // capture the word.
    assign pop = rst_n && enable && !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && baud_end));

    assign fifo_rd    = pop;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && baud_end;

    always_comb begin
        next_state  = state;
        next_baud   = baud_cnt + 16'd1;
        next_bit    = bit_cnt;
        next_shreg  = shreg;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        next_parity = parity;
`endif

        case (state)
            IDLE: begin
                next_baud = 16'd0;
                if (pop) begin
                    next_state  = START;
                    next_shreg  = fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    next_parity = ^fifo_data;
`endif
                end
            end

            START: begin
                if (baud_end) begin
                    next_state = DATA;
                    next_baud  = 16'd0;
                end
            end

            DATA: begin
                if (baud_end) begin
                    next_baud  = 16'd0;
                    // Shift on every bit end so shreg[0] is always the bit on air.
                    next_shreg = {1'b0, shreg[7:1]};
                    next_bit   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end
            end

`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    next_state = STOP;
                    next_baud  = 16'd0;
                end
            end
`endif

            STOP: begin
                if (baud_end) begin
                    next_baud = 16'd0;
                    if (pop) begin
                        next_state  = START;
                        next_shreg  = fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        next_parity = ^fifo_data;
`endif
                    end else begin
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
                next_baud  = 16'd0;
            end
        endcase
    end

    // tx is registered from the state being entered, so the line changes on
    // the same edge as the state and the START bit begins right after the pop.
    always_comb begin
        next_tx = 1'b1;
        case (next_state)
            IDLE:    next_tx = 1'b1;
            START:   next_tx = 1'b0;
            DATA:    next_tx = next_shreg[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY:  next_tx = parity;
`endif
            STOP:    next_tx = 1'b1;
            default: next_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            tx       <= 1'b1;
        end else begin
            state    <= next_state;
            baud_cnt <= next_baud;
            bit_cnt  <= next_bit;
            shreg    <= next_shreg;
            tx       <= next_tx;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else begin
            parity <= next_parity;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - directed self-checking bench for fifo_serial_tx

module tb_fifo_serial_tx;

    localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:7];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr % 8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    fifo_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 8] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected line level for serial bit index pos (0 = START) of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef FIFO_SERIAL_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic etx, input logic ebusy,
                       input logic erd, input logic edone);
        checks++;
        assert (tx === etx) else begin
            errors++;
            $error("FAIL %s tx got %b exp %b", tag, tx, etx);
        end
        checks++;
        assert (busy === ebusy) else begin
            errors++;
            $error("FAIL %s busy got %b exp %b", tag, busy, ebusy);
        end
        checks++;
        assert (fifo_rd === erd) else begin
            errors++;
            $error("FAIL %s fifo_rd got %b exp %b", tag, fifo_rd, erd);
        end
        checks++;
        assert (frame_done === edone) else begin
            errors++;
            $error("FAIL %s frame_done got %b exp %b", tag, frame_done, edone);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        chk("reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // Single frame 0xA5
        rst_n = 1'b1;
        step();
        push(8'hA5);
        enable = 1'b1;
        #1;
        chk("a5 pop", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            chk($sformatf("a5 k=%0d", k), exp_bit(8'hA5, (k-1)/CPB), 1'b1,
                1'b0, k == FRAME);
        end
        step();
        chk("a5 idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back 0x55, 0xAA
        enable = 1'b0;
        step();
        push(8'h55);
        push(8'hAA);
        enable = 1'b1;
        #1;
        chk("b2b pop0", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 2*FRAME; k++) begin
            logic [7:0] b;
            step();
            b = ((k-1)/FRAME == 0) ? 8'h55 : 8'hAA;
            chk($sformatf("b2b k=%0d", k), exp_bit(b, ((k-1)%FRAME)/CPB), 1'b1,
                k == FRAME, (k % FRAME) == 0);
        end
        step();
        chk("b2b idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Empty FIFO with enable held high
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("empty k=%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // enable dropped mid-frame: 0x0F sent, 0x3C stays in the FIFO
        enable = 1'b0;
        step();
        push(8'h0F);
        push(8'h3C);
        enable = 1'b1;
        #1;
        chk("drop pop", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            chk($sformatf("drop k=%0d", k), exp_bit(8'h0F, (k-1)/CPB), 1'b1,
                1'b0, k == FRAME);
            if (k == 10) enable = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("drop idle k=%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-frame of 0x3C, then 0x81 popped in the first IDLE cycle
        push(8'h81);
        enable = 1'b1;
        #1;
        chk("rst pop", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("rst k=%0d", k), exp_bit(8'h3C, (k-1)/CPB), 1'b1,
                1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("rst asserted", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("rst held", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst release pop", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            chk($sformatf("post k=%0d", k), exp_bit(8'h81, (k-1)/CPB), 1'b1,
                1'b0, k == FRAME);
        end
        step();
        chk("post idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
